// File: rtl/instr_encoder.sv
// instr_encoder: packs MIPS R-type (add/sub/and/or/xor/nor) and I-type
// (lw/sw/addi) instruction fields into 32-bit words and writes them to
// consecutive instruction-memory addresses over an acknowledged write port.
// Optional feature macro: INSTR_ENC_WRAP_EN (wrap the write pointer to 0
// after the last address instead of stopping in FULL).
module instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [3:0]        i_op_sel,
  input  logic [4:0]        i_rs,
  input  logic [4:0]        i_rt,
  input  logic [4:0]        i_rd,
  input  logic [15:0]       i_imm,
  output logic              o_mem_we,
  input  logic              i_mem_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    WR   = 2'd2,
    FULL = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  state_t            w_state_next;

  logic [3:0]        r_op;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;
  logic [15:0]       r_imm;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;

  logic              w_legal;
  logic [31:0]       w_word;
  logic              w_accept;
  logic              w_write_done;
  logic              w_last_addr;

  // Instruction encoding from the latched field set; illegal selects flagged
  always_comb begin
    w_legal = 1'b1;
    w_word  = 32'h0000_0000;
    case (r_op)
      4'd0: w_word = {6'h00, r_rs, r_rt, r_rd, 5'd0, 6'h20};
      4'd1: w_word = {6'h00, r_rs, r_rt, r_rd, 5'd0, 6'h22};
      4'd2: w_word = {6'h00, r_rs, r_rt, r_rd, 5'd0, 6'h24};
      4'd3: w_word = {6'h00, r_rs, r_rt, r_rd, 5'd0, 6'h25};
      4'd4: w_word = {6'h00, r_rs, r_rt, r_rd, 5'd0, 6'h26};
      4'd5: w_word = {6'h00, r_rs, r_rt, r_rd, 5'd0, 6'h27};
      4'd6: w_word = {6'h23, r_rs, r_rt, r_imm};
      4'd7: w_word = {6'h2b, r_rs, r_rt, r_imm};
      4'd8: w_word = {6'h08, r_rs, r_rt, r_imm};
      default: w_legal = 1'b0;
    endcase
  end

  assign w_accept     = (r_state == IDLE) && i_in_valid && !i_clr;
  assign w_write_done = (r_state == WR) && i_mem_ack && !i_clr;
  assign w_last_addr  = (r_ptr == LAST_ADDR);

  // Next-state logic; clr forces IDLE from any state, even over an ack
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (i_in_valid) w_state_next = ENC;
      ENC:  w_state_next = w_legal ? WR : IDLE;
      WR: begin
        if (i_mem_ack) begin
`ifdef INSTR_ENC_WRAP_EN
          w_state_next = IDLE;
`else
          w_state_next = w_last_addr ? FULL : IDLE;
`endif
        end
      end
      FULL: w_state_next = FULL;
      default: w_state_next = IDLE;
    endcase
    if (i_clr) w_state_next = IDLE;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Field capture on accept; encoded word registered in ENC and held through WR
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op    <= 4'd0;
      r_rs    <= 5'd0;
      r_rt    <= 5'd0;
      r_rd    <= 5'd0;
      r_imm   <= 16'h0000;
      r_wdata <= 32'h0000_0000;
    end else begin
      if (w_accept) begin
        r_op  <= i_op_sel;
        r_rs  <= i_rs;
        r_rt  <= i_rt;
        r_rd  <= i_rd;
        r_imm <= i_imm;
      end
      if ((r_state == ENC) && w_legal && !i_clr) r_wdata <= w_word;
    end
  end

  // Write pointer and saturating word count advance only on a taken write
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (w_write_done) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_count != COUNT_MAX) r_count <= r_count + 1'b1;
    end
  end

`ifdef INSTR_ENC_WRAP_EN
  assign o_full = 1'b0;
`else
  logic r_full;

  // Full flag registered alongside entry into FULL; clr/reset release it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_full <= 1'b0;
    else          r_full <= (w_state_next == FULL);
  end

  assign o_full = r_full;
`endif

  assign o_in_ready  = (r_state == IDLE);
  assign o_mem_we    = (r_state == WR);
  assign o_mem_addr  = r_ptr;
  assign o_mem_wdata = r_wdata;
  assign o_count     = r_count;
  assign o_err       = (r_state == ENC) && !w_legal;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder: the inverse of the control/decode path. Accepts operation selects and register/immediate fields over a valid/ready handshake, packs them into 32-bit instruction words (R-type add/sub/and/or/xor/nor, I-type lw/sw/addi), and writes them to consecutive instruction-memory addresses through an acknowledged write port. Used to load programs into instruction memory for the datapath labs.

## Interface
- ADDR_W, 6: instruction-memory word-address width; depth = 2**ADDR_W.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous clear: pointer, count, full to 0; state to IDLE.
- in_valid  in  1  field set valid.
- in_ready  out  1  encoder can accept; high only in IDLE.
- op_sel  in  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 lw, 7 sw, 8 addi, 9–15 illegal.
- rs, rt, rd  in  5 each  register fields; rd ignored for I-type.
- imm  in  16  immediate; ignored for R-type.
- mem_we  out  1  write request, held until acked.
- mem_ack  in  1  memory accepted write this cycle.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since reset/clr.
- full  out  1  memory full, no further accepts.
- err  out  1  one-cycle pulse on illegal op_sel.

## Operation
- States: IDLE, ENC, WR, FULL.
- IDLE: in_ready=1. On in_valid: latch op_sel/rs/rt/rd/imm, go ENC.
- ENC: legal op → register encoded word into mem_wdata, go WR. Illegal op → err=1 this cycle, no write, no pointer change, go IDLE.
- R-type: opcode 0, rs[25:21], rt[20:16], rd[15:11], shamt 0, funct = 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor.
- I-type: opcode[31:26] = 0x23 lw, 0x2b sw, 0x08 addi; rs[25:21], rt[20:16], imm[15:0] verbatim.
- WR: mem_we=1, mem_addr=wr_ptr, mem_wdata stable until mem_ack. On mem_ack: count+1 (saturating at 2**ADDR_W), wr_ptr+1; if wr_ptr was 2**ADDR_W−1, go FULL (unless wrap enabled, see Configuration), else IDLE.
- FULL: full=1, in_ready=0, mem_we=0; leave only via clr or reset.
- clr overrides everything, any state, including WR with mem_ack same cycle (write counts as not taken).
- Reset mid-operation: pending word discarded, no write issued.

## Timing
- Reset values: in_ready=1 (IDLE), mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0.
- Accept edge T; ENC at T+1; mem_we rises T+2; with mem_ack at T+2, IDLE (in_ready=1) at T+3. Min 3 cycles/instruction.
- Each cycle without mem_ack in WR adds one cycle; outputs held constant.
- mem_ack outside WR ignored.
- err asserted exactly one cycle (ENC), in_ready back at next cycle.
- full registered; rises the cycle after the final ack.

## Configuration
- INSTR_ENC_WRAP_EN defined: after write to address 2**ADDR_W−1, wr_ptr wraps to 0 and state returns to IDLE; FULL never entered, full tied 0; count still saturates.
- Undefined: behaviour as in Operation (stop in FULL).

## Test plan
- add rd=3 rs=1 rt=2 -> mem_wdata=0x00221820, mem_addr=0, mem_we at T+2, count=1.
- lw rt=8 rs=29 imm=0x0004, then sw rt=9 rs=4 imm=0xFFFC, mem_ack delayed 3 cycles on second -> 0x8FA80004 @0, 0xAC89FFFC @1, word/address held during stall.
- addi rt=5 rs=0 imm=7 and nor rd=10 rs=11 rt=12 -> 0x20050007, 0x016C5027.
- op_sel=12 -> err one cycle, no mem_we, count unchanged, in_ready high at T+2.
- ADDR_W=2, 4 writes -> full=1, in_ready=0, 5th in_valid ignored; with INSTR_ENC_WRAP_EN, 5th lands at addr 0, full stays 0; clr -> count=0, mem_addr=0.
- rst_n low while in WR -> mem_we drops immediately, all outputs at reset values, no ack-driven count change.
